mode_switch_controller: RTL and testbench

- Sequences a video mode change from the 5-position mode switch.
- Decodes the raw switch pattern and debounces it, then blanks video output and triggers PLL/timing reconfiguration.
- Waits for PLL lock, then re-enables video.
- Sits between the switch pins and the video timing generator/PLL reconfig block; it is the single owner of the active mode word.

---
 rtl/mode_switch_controller_pkg.sv | 63 ++++++
 rtl/mode_switch_controller_if.sv | 40 ++++
 rtl/mode_switch_debouncer.sv | 61 ++++++
 rtl/mode_switch_controller.sv | 162 ++++++++++++++++
 tb/tb_mode_switch_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mode_switch_controller_pkg.sv
// Mode slot codes, state encodings and switch decode for mode_switch_controller.
// Shared by the controller, its debouncer and its interface.
`ifndef MODE_SWITCH_DEFINES
`define MODE_SWITCH_DEFINES
`define MODE_SIZE 3
`define SLOT1 3'd1
`define SLOT2 3'd2
`define SLOT3 3'd3
`define SLOT4 3'd4
`define SLOT5 3'd5
`define ST_RUN 3'd0
`define ST_DEBOUNCE 3'd1
`define ST_BLANK 3'd2
`define ST_RECONFIG 3'd3
`define ST_WAIT_DONE 3'd4
`define ST_WAIT_LOCK 3'd5
`endif

package mode_switch_controller_pkg;

  localparam int MODE_W = `MODE_SIZE;
  localparam int PINS = 5;

  typedef logic [MODE_W-1:0] mode_t;
  typedef logic [PINS-1:0] pins_t;

  localparam mode_t SLOT1 = `SLOT1;
  localparam mode_t SLOT2 = `SLOT2;
  localparam mode_t SLOT3 = `SLOT3;
  localparam mode_t SLOT4 = `SLOT4;
  localparam mode_t SLOT5 = `SLOT5;

  typedef enum logic [2:0] {
    S_RUN       = `ST_RUN,
    S_DEBOUNCE  = `ST_DEBOUNCE,
    S_BLANK     = `ST_BLANK,
    S_RECONFIG  = `ST_RECONFIG,
    S_WAIT_DONE = `ST_WAIT_DONE,
    S_WAIT_LOCK = `ST_WAIT_LOCK
  } state_t;

  typedef struct packed {
    logic  valid;
    mode_t mode;
  } decode_t;

  // Each slot accepts its one-hot pattern or its bitwise inverse.
  function automatic decode_t decode(input pins_t p);
    decode_t d;
    d.valid = 1'b1;
    d.mode  = SLOT1;
    case (p)
      5'b00001, 5'b11110: d.mode = SLOT1;
      5'b00010, 5'b11101: d.mode = SLOT2;
      5'b00100, 5'b11011: d.mode = SLOT3;
      5'b01000, 5'b10111: d.mode = SLOT4;
      5'b10000, 5'b01111: d.mode = SLOT5;
      default:            d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mode_switch_controller_if.sv
// Switch, PLL-handshake and video-control signals of mode_switch_controller.
// slave is the controller side, master is the environment side.
interface mode_switch_controller_if;
  import mode_switch_controller_pkg::*;

  pins_t config_in;
  logic  reconfig_done;
  logic  pll_locked;
  mode_t mode_data;
  logic  reconfig_start;
  logic  video_enable;
  logic  config_changed;
  logic  busy;
  logic  lock_error;

  modport master (
    output config_in,
    output reconfig_done,
    output pll_locked,
    input  mode_data,
    input  reconfig_start,
    input  video_enable,
    input  config_changed,
    input  busy,
    input  lock_error
  );

  modport slave (
    input  config_in,
    input  reconfig_done,
    input  pll_locked,
    output mode_data,
    output reconfig_start,
    output video_enable,
    output config_changed,
    output busy,
    output lock_error
  );

endinterface

// File: rtl/mode_switch_debouncer.sv
// Synchronises switch pins and PLL lock, decodes the pins and
// reports when a candidate pattern has held for DEBOUNCE_CYCLES.
module mode_switch_debouncer
  import mode_switch_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic    clock,
  input  logic    reset,
  input  pins_t   pins,
  input  logic    lock_raw,
  input  logic    restart,
  output logic    locked,
  output decode_t live,
  output logic    settled,
  output logic    stable_valid,
  output mode_t   stable_mode
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  pins_t         pins_meta;
  pins_t         pins_sync;
  pins_t         cand;
  logic          lock_meta;
  logic          lock_sync;
  logic [CW-1:0] count;
  decode_t       cand_dec;

  always_ff @(posedge clock) begin
    if (reset) begin
      pins_meta <= '0;
      pins_sync <= '0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      cand      <= '0;
      count     <= '0;
    end else begin
      pins_meta <= pins;
      pins_sync <= pins_meta;
      lock_meta <= lock_raw;
      lock_sync <= lock_meta;
      // Any pattern change restarts the stability window.
      if (restart || pins_sync != cand) begin
        cand  <= pins_sync;
        count <= '0;
      end else if (count != LAST) begin
        count <= count + 1'b1;
      end
    end
  end

  assign live         = decode(pins_sync);
  assign cand_dec     = decode(cand);
  assign settled      = (count == LAST) && (pins_sync == cand);
  assign stable_valid = settled && cand_dec.valid;
  assign stable_mode  = cand_dec.mode;
  assign locked       = lock_sync;

endmodule

// File: rtl/mode_switch_controller.sv
// Sequences a video mode change: debounce, blank, PLL reconfig, lock.
// MODE_SWITCH_LOCK_TIMEOUT_EN enables the lock timeout retry and lock_error.
module mode_switch_controller
  import mode_switch_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLANK_CYCLES    = 1024,
  parameter int LOCK_TIMEOUT    = 1048576
) (
  input  logic                     clock,
  input  logic                     reset,
  mode_switch_controller_if.slave  bus
);

`ifdef MODE_SWITCH_LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int TMAX =
    (BLANK_CYCLES > LOCK_TIMEOUT) ? BLANK_CYCLES : LOCK_TIMEOUT;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  mode_t         mode_q;
  mode_t         target;
  logic          force_apply;
  logic          from_run;
  logic [TW-1:0] timer;

  logic    restart;
  logic    capture;
  logic    changed;
  logic    expired;
  logic    waiting;
  logic    count_en;
  logic    timer_keep;
  logic    locked;
  decode_t live;
  logic    settled;
  logic    stable_valid;
  mode_t   stable_mode;

  mode_switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .pins        (bus.config_in),
    .lock_raw    (bus.pll_locked),
    .restart     (restart),
    .locked      (locked),
    .live        (live),
    .settled     (settled),
    .stable_valid(stable_valid),
    .stable_mode (stable_mode)
  );

  assign waiting  = (state == S_WAIT_DONE) || (state == S_WAIT_LOCK);
  assign expired  = TIMEOUT_EN && waiting && (timer == TIMEOUT_LAST);
  assign count_en = (state == S_BLANK) || (TIMEOUT_EN && waiting);

  // The timeout spans both wait states, so that hop keeps the count.
  assign timer_keep = (state_next == state) ||
    ((state == S_WAIT_DONE) && (state_next == S_WAIT_LOCK));

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    capture    = 1'b0;
    changed    = 1'b0;
    unique case (state)
      S_RUN: begin
        if (live.valid && live.mode != mode_q) begin
          restart    = 1'b1;
          state_next = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (settled) begin
          if (stable_valid &&
              (stable_mode != mode_q || force_apply)) begin
            capture    = 1'b1;
            state_next = S_BLANK;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_BLANK: begin
        if (timer == BLANK_LAST) state_next = S_RECONFIG;
      end
      S_RECONFIG: begin
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.reconfig_done) state_next = S_WAIT_LOCK;
        else if (expired)      state_next = S_RECONFIG;
      end
      S_WAIT_LOCK: begin
        if (locked) begin
          changed    = 1'b1;
          state_next = S_RUN;
        end else if (expired) begin
          state_next = S_RECONFIG;
        end
      end
      default: begin
        state_next = S_DEBOUNCE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_DEBOUNCE;
      mode_q      <= SLOT1;
      target      <= SLOT1;
      force_apply <= 1'b1;
      from_run    <= 1'b0;
      timer       <= '0;
    end else begin
      state <= state_next;
      if (capture) target <= stable_mode;
      if (state == S_RECONFIG) mode_q <= target;
      if (changed) force_apply <= 1'b0;
      // Video keeps running while a change from RUN is debounced.
      if (state == S_RUN) from_run <= 1'b1;
      else if (state == S_BLANK) from_run <= 1'b0;
      if (!timer_keep) timer <= '0;
      else if (count_en) timer <= timer + 1'b1;
    end
  end

`ifdef MODE_SWITCH_LOCK_TIMEOUT_EN
  logic lock_error_q;
  logic retry;

  assign retry = waiting && (state_next == S_RECONFIG);

  always_ff @(posedge clock) begin
    if (reset) lock_error_q <= 1'b0;
    else if (retry) lock_error_q <= 1'b1;
  end

  assign bus.lock_error = lock_error_q;
`else
  assign bus.lock_error = 1'b0;
`endif

  assign bus.mode_data      = mode_q;
  assign bus.reconfig_start = (state == S_RECONFIG);
  assign bus.config_changed = changed;
  assign bus.busy           = (state != S_RUN);
  assign bus.video_enable   = (state == S_RUN) ||
    ((state == S_DEBOUNCE) && from_run);

endmodule

// File: tb/tb_mode_switch_controller.sv
// Directed bench for mode_switch_controller with shortened timing.
// Define MODE_SWITCH_LOCK_TIMEOUT_EN to cover the lock timeout retry.
module tb_mode_switch_controller;
  import mode_switch_controller_pkg::*;

  localparam int DEB = 16;
  localparam int BLK = 8;
  localparam int LTO = 40;
  localparam int LAT = 2 + DEB + BLK + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mode_switch_controller_if bus ();

  mode_switch_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .BLANK_CYCLES   (BLK),
    .LOCK_TIMEOUT   (LTO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    pins_t cfg;
    logic  done;
    logic  lock;
    int    cycles;
    mode_t mode;
    logic  ven;
    logic  busy;
    int    nstart;
    int    nchange;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int changes = 0;

  always @(negedge clock) begin
    if (bus.reconfig_start === 1'b1) starts++;
    if (bus.config_changed === 1'b1) changes++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_done();
    bus.reconfig_done = 1'b1;
    step(1);
    bus.reconfig_done = 1'b0;
  endtask

  task automatic wait_mode(input mode_t m, input string name,
                           output int lat);
    lat = 0;
    while (bus.mode_data != m && lat < 200) begin
      step(1);
      lat++;
    end
    check(name, int'(bus.mode_data), int'(m));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " mode"}, int'(bus.mode_data), int'(SLOT1));
    check({tag, " video_enable"}, int'(bus.video_enable), 0);
    check({tag, " reconfig_start"}, int'(bus.reconfig_start), 0);
    check({tag, " config_changed"}, int'(bus.config_changed), 0);
    check({tag, " busy"}, int'(bus.busy), 1);
    check({tag, " lock_error"}, int'(bus.lock_error), 0);
  endtask

  initial begin
    int s0, c0, lat_a, lat_b;
    bus.config_in     = 5'b00100;
    bus.reconfig_done = 1'b0;
    bus.pll_locked    = 1'b0;
    // power-up to SLOT3, then SLOT1, glitch, invalid, stray done
    vecs.push_back('{5'b00100, 1'b0, 1'b0, 40, SLOT3, 1'b0, 1'b1, 1, 0});
    vecs.push_back('{5'b00100, 1'b1, 1'b0, 1, SLOT3, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{5'b00100, 1'b0, 1'b1, 6, SLOT3, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{5'b00001, 1'b0, 1'b0, 40, SLOT1, 1'b0, 1'b1, 1, 0});
    vecs.push_back('{5'b00001, 1'b1, 1'b0, 1, SLOT1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{5'b00001, 1'b0, 1'b1, 6, SLOT1, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{5'b01000, 1'b0, 1'b1, 8, SLOT1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{5'b00001, 1'b0, 1'b1, 8, SLOT1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{5'b01000, 1'b0, 1'b1, 8, SLOT1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{5'b00001, 1'b0, 1'b1, 30, SLOT1, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{5'b00011, 1'b0, 1'b1, 40, SLOT1, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{5'b00011, 1'b1, 1'b1, 1, SLOT1, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{5'b00001, 1'b0, 1'b1, 5, SLOT1, 1'b1, 1'b0, 0, 0});

    step(3);
    reset_checks("reset");
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      s0 = starts;
      c0 = changes;
      bus.config_in     = vecs[i].cfg;
      bus.reconfig_done = vecs[i].done;
      bus.pll_locked    = vecs[i].lock;
      step(vecs[i].cycles);
      check($sformatf("v%0d mode", i),
            int'(bus.mode_data), int'(vecs[i].mode));
      check($sformatf("v%0d video_enable", i),
            int'(bus.video_enable), int'(vecs[i].ven));
      check($sformatf("v%0d busy", i),
            int'(bus.busy), int'(vecs[i].busy));
      check($sformatf("v%0d start pulses", i),
            starts - s0, vecs[i].nstart);
      check($sformatf("v%0d change pulses", i),
            changes - c0, vecs[i].nchange);
    end
    bus.reconfig_done = 1'b0;

    // inverted pattern must take the same path and latency
    bus.config_in  = 5'b00010;
    bus.pll_locked = 1'b0;
    wait_mode(SLOT2, "plain mode", lat_a);
    pulse_done();
    bus.pll_locked = 1'b1;
    step(6);
    bus.config_in  = 5'b11011;
    bus.pll_locked = 1'b0;
    wait_mode(SLOT3, "inverted mode", lat_b);
    check("inverted latency", lat_b, lat_a);
    check("plain latency window",
          int'(lat_a >= LAT - 1 && lat_a <= LAT + 1), 1);
    pulse_done();
    bus.pll_locked = 1'b1;
    step(6);
    check("inverted video_enable", int'(bus.video_enable), 1);
    check("inverted busy", int'(bus.busy), 0);

    // switch change while waiting for lock
    s0 = starts;
    c0 = changes;
    bus.config_in  = 5'b10000;
    bus.pll_locked = 1'b0;
    wait_mode(SLOT5, "first seq mode", lat_a);
    pulse_done();
    step(3);
    bus.config_in = 5'b00001;
    step(10);
    check("held mode", int'(bus.mode_data), int'(SLOT5));
    check("held busy", int'(bus.busy), 1);
    check("held video_enable", int'(bus.video_enable), 0);
    check("held changes", changes - c0, 0);
    bus.pll_locked = 1'b1;
    step(6);
    check("first seq changes", changes - c0, 1);
    wait_mode(SLOT1, "second seq mode", lat_a);
    pulse_done();
    step(6);
    check("two seq changes", changes - c0, 2);
    check("two seq starts", starts - s0, 2);
    check("two seq busy", int'(bus.busy), 0);
    check("two seq video_enable", int'(bus.video_enable), 1);

`ifdef MODE_SWITCH_LOCK_TIMEOUT_EN
    bus.config_in  = 5'b01000;
    bus.pll_locked = 1'b0;
    wait_mode(SLOT4, "timeout mode", lat_a);
    s0 = starts;
    pulse_done();
    check("pre timeout lock_error", int'(bus.lock_error), 0);
    step(50);
    check("timeout lock_error", int'(bus.lock_error), 1);
    check("timeout retry starts", starts - s0, 1);
    check("timeout mode kept", int'(bus.mode_data), int'(SLOT4));
    pulse_done();
    step(3);
    check("mid wait_lock busy", int'(bus.busy), 1);
`else
    bus.config_in = 5'b00100;
    step(22);
    check("blank video_enable", int'(bus.video_enable), 0);
    check("blank busy", int'(bus.busy), 1);
    check("blank mode", int'(bus.mode_data), int'(SLOT1));
`endif
    reset = 1'b1;
    step(1);
    reset_checks("mid reset");

    // power-up setting equal to SLOT1 is still applied
    bus.config_in  = 5'b00001;
    bus.pll_locked = 1'b1;
    step(2);
    reset = 1'b0;
    s0 = starts;
    c0 = changes;
    step(40);
    check("forced starts", starts - s0, 1);
    check("forced mode", int'(bus.mode_data), int'(SLOT1));
    check("forced busy", int'(bus.busy), 1);
    pulse_done();
    step(6);
    check("forced changes", changes - c0, 1);
    check("forced video_enable", int'(bus.video_enable), 1);
    check("forced lock_error", int'(bus.lock_error), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
